cdb_arbiter: RTL and testbench

- Shares the common data bus (CDB) among the functional-unit result ports (ALU, MUL, LOAD, BR) fed by the issue stage.
- Each FU result is captured into a one-entry holding register. Up to CDB_WIDTH held results are granted per cycle, round-robin.
- Granted results are driven onto registered CDB outputs for RS wakeup, ROB completion and PRF write.
- A branch-mispredict flush squashes everything held or in flight.

---
 rtl/cdb_arbiter_pkg.sv | 22 ++
 rtl/rr_multi_picker.sv | 41 ++++
 rtl/cdb_arbiter.sv | 109 ++++++++++
 tb/tb_cdb_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
package cdb_arbiter_pkg;

    localparam int unsigned PHYS_REGS = 128;
    localparam int unsigned ROB_DEPTH = 64;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned TAGW      = $clog2(PHYS_REGS);
    localparam int unsigned ROBW      = $clog2(ROB_DEPTH);

    localparam int unsigned FU_IDX_ALU  = 0;
    localparam int unsigned FU_IDX_MUL  = 1;
    localparam int unsigned FU_IDX_LOAD = 2;
    localparam int unsigned FU_IDX_BR   = 3;

    typedef struct packed {
        logic            valid;
        logic [TAGW-1:0] dest_tag;
        logic [ROBW-1:0] rob_idx;
        logic [XLEN-1:0] value;
    } cdb_packet_t;

endpackage

// File: rtl/rr_multi_picker.sv
// Round-robin picker granting up to CDB_WIDTH requests per cycle, starting at a pointer.
module rr_multi_picker #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CDB_WIDTH = 1,
    localparam int unsigned PTRW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [PTRW-1:0]                     start,
    output logic [NUM_REQ-1:0]                  grant,
    output logic [CDB_WIDTH-1:0]                slot_valid,
    output logic [CDB_WIDTH-1:0][PTRW-1:0]      slot_sel,
    output logic [PTRW-1:0]                     last_idx
);

    // Walk requesters in rotated order, filling slots 0..CDB_WIDTH-1 in scan order.
    always_comb begin
        int unsigned     taken;
        logic [PTRW-1:0] idx;
        grant      = '0;
        slot_valid = '0;
        slot_sel   = '0;
        last_idx   = start;
        taken      = 0;
        idx        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTRW'((32'(start) + k) % NUM_REQ);
            if (req[idx] && (taken < CDB_WIDTH)) begin
                grant[idx] = 1'b1;
                for (int unsigned s = 0; s < CDB_WIDTH; s++) begin
                    if (s == taken) begin
                        slot_valid[s] = 1'b1;
                        slot_sel[s]   = idx;
                    end
                end
                last_idx = idx;
                taken    = taken + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Holds one result per functional unit and broadcasts up to CDB_WIDTH of them per cycle, round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CDB_WIDTH = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush_i,
    input  logic [NUM_REQ-1:0]                fu_valid_i,
    input  logic [NUM_REQ-1:0][TAGW-1:0]      fu_dest_tag_i,
    input  logic [NUM_REQ-1:0][ROBW-1:0]      fu_rob_idx_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]      fu_value_i,
    output logic [NUM_REQ-1:0]                fu_ready_o,
    output logic [CDB_WIDTH-1:0]              cdb_valid_o,
    output logic [CDB_WIDTH-1:0][TAGW-1:0]    cdb_tag_o,
    output logic [CDB_WIDTH-1:0][ROBW-1:0]    cdb_rob_idx_o,
    output logic [CDB_WIDTH-1:0][XLEN-1:0]    cdb_value_o
);

    localparam int unsigned PTRW = $clog2(NUM_REQ);

    cdb_packet_t                      hold_q [NUM_REQ];
    cdb_packet_t                      cdb_q  [CDB_WIDTH];
    logic [PTRW-1:0]                  rr_ptr_q;
    logic [NUM_REQ-1:0]               hold_valid;
    logic [NUM_REQ-1:0]               grant;
    logic [CDB_WIDTH-1:0]             slot_valid;
    logic [CDB_WIDTH-1:0][PTRW-1:0]   slot_sel;
    logic [PTRW-1:0]                  last_idx;

    always_comb begin
        hold_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            hold_valid[i] = hold_q[i].valid;
        end
    end

    rr_multi_picker #(
        .NUM_REQ   (NUM_REQ),
        .CDB_WIDTH (CDB_WIDTH)
    ) u_picker (
        .req        (hold_valid),
        .start      (rr_ptr_q),
        .grant      (grant),
        .slot_valid (slot_valid),
        .slot_sel   (slot_sel),
        .last_idx   (last_idx)
    );

    // Depends only on registered state, so an FU may gate fu_valid_i on it without a loop.
    assign fu_ready_o = ~hold_valid | grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                hold_q[i] <= '0;
            end
            for (int unsigned s = 0; s < CDB_WIDTH; s++) begin
                cdb_q[s] <= '0;
            end
            rr_ptr_q <= '0;
        end else if (flush_i) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                hold_q[i].valid <= 1'b0;
            end
            for (int unsigned s = 0; s < CDB_WIDTH; s++) begin
                cdb_q[s].valid <= 1'b0;
            end
            rr_ptr_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (fu_valid_i[i] && fu_ready_o[i]) begin
                    hold_q[i] <= '{valid:    1'b1,
                                   dest_tag: fu_dest_tag_i[i],
                                   rob_idx:  fu_rob_idx_i[i],
                                   value:    fu_value_i[i]};
                end else if (grant[i]) begin
                    hold_q[i].valid <= 1'b0;
                end
            end
            for (int unsigned s = 0; s < CDB_WIDTH; s++) begin
                if (slot_valid[s]) begin
                    cdb_q[s] <= hold_q[slot_sel[s]];
                end else begin
                    cdb_q[s].valid <= 1'b0;
                end
            end
            if (|grant) begin
                rr_ptr_q <= PTRW'((32'(last_idx) + 1) % NUM_REQ);
            end
        end
    end

    always_comb begin
        cdb_valid_o   = '0;
        cdb_tag_o     = '0;
        cdb_rob_idx_o = '0;
        cdb_value_o   = '0;
        for (int unsigned s = 0; s < CDB_WIDTH; s++) begin
            cdb_valid_o[s]   = cdb_q[s].valid;
            cdb_tag_o[s]     = cdb_q[s].dest_tag;
            cdb_rob_idx_o[s] = cdb_q[s].rob_idx;
            cdb_value_o[s]   = cdb_q[s].value;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Drives a 1-wide and a 2-wide arbiter with directed and random FU traffic against a reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic clock;
    logic reset;
    logic flush;

    logic [3:0]           in_v [2];
    logic [3:0][TAGW-1:0] in_t [2];
    logic [3:0][ROBW-1:0] in_r [2];
    logic [3:0][XLEN-1:0] in_d [2];

    logic [3:0]           rdy1, rdy2;
    logic [0:0]           c1_v;
    logic [0:0][TAGW-1:0] c1_t;
    logic [0:0][ROBW-1:0] c1_r;
    logic [0:0][XLEN-1:0] c1_d;
    logic [1:0]           c2_v;
    logic [1:0][TAGW-1:0] c2_t;
    logic [1:0][ROBW-1:0] c2_r;
    logic [1:0][XLEN-1:0] c2_d;

    cdb_arbiter #(.NUM_REQ(4), .CDB_WIDTH(1)) u_w1 (
        .clock(clock), .reset(reset), .flush_i(flush),
        .fu_valid_i(in_v[0]), .fu_dest_tag_i(in_t[0]), .fu_rob_idx_i(in_r[0]), .fu_value_i(in_d[0]),
        .fu_ready_o(rdy1),
        .cdb_valid_o(c1_v), .cdb_tag_o(c1_t), .cdb_rob_idx_o(c1_r), .cdb_value_o(c1_d)
    );

    cdb_arbiter #(.NUM_REQ(4), .CDB_WIDTH(2)) u_w2 (
        .clock(clock), .reset(reset), .flush_i(flush),
        .fu_valid_i(in_v[1]), .fu_dest_tag_i(in_t[1]), .fu_rob_idx_i(in_r[1]), .fu_value_i(in_d[1]),
        .fu_ready_o(rdy2),
        .cdb_valid_o(c2_v), .cdb_tag_o(c2_t), .cdb_rob_idx_o(c2_r), .cdb_value_o(c2_d)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: per-FU held result, rotating pointer, expected bus.
    bit            m_hv [2][4];
    logic [TAGW-1:0] m_ht [2][4];
    logic [ROBW-1:0] m_hr [2][4];
    logic [XLEN-1:0] m_hd [2][4];
    int            m_rr [2];
    bit            e_v  [2][2];
    logic [TAGW-1:0] e_t [2][2];
    logic [ROBW-1:0] e_r [2][2];
    logic [XLEN-1:0] e_d [2][2];
    bit            e_rst [2];
    int            pk_list [2][4];
    int            pk_n [2];
    bit [3:0]      pk_g [2];
    bit [3:0]      rdy_exp [2];

    // FU-side pending results, held until accepted
    bit            p_v [2][4];
    logic [TAGW-1:0] p_t [2][4];
    logic [ROBW-1:0] p_r [2][4];
    logic [XLEN-1:0] p_d [2][4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int wid(input int m);
        return (m == 0) ? 1 : 2;
    endfunction

    function automatic logic [63:0] obs_f(input int m, input int s, input int f);
        if (m == 0) begin
            case (f)
                0: return 64'(c1_v[0]);
                1: return 64'(c1_t[0]);
                2: return 64'(c1_r[0]);
                default: return 64'(c1_d[0]);
            endcase
        end
        case (f)
            0: return 64'(c2_v[s[0]]);
            1: return 64'(c2_t[s[0]]);
            2: return 64'(c2_r[s[0]]);
            default: return 64'(c2_d[s[0]]);
        endcase
    endfunction

    task automatic model_clear(input int m);
        for (int i = 0; i < 4; i++) begin
            m_hv[m][i] = 0; m_ht[m][i] = '0; m_hr[m][i] = '0; m_hd[m][i] = '0;
        end
        for (int s = 0; s < 2; s++) begin
            e_v[m][s] = 0; e_t[m][s] = '0; e_r[m][s] = '0; e_d[m][s] = '0;
        end
        m_rr[m]  = 0;
        e_rst[m] = 1;
    endtask

    // Valid entries in rotated order; the first W of them win.
    task automatic model_pick(input int m);
        int q[$];
        q = {};
        for (int k = 0; k < 4; k++) begin
            if (m_hv[m][(m_rr[m] + k) % 4]) q.push_back((m_rr[m] + k) % 4);
        end
        pk_n[m] = (q.size() < wid(m)) ? q.size() : wid(m);
        pk_g[m] = '0;
        for (int j = 0; j < pk_n[m]; j++) begin
            pk_list[m][j] = q[j];
            pk_g[m][q[j]] = 1'b1;
        end
    endtask

    task automatic load(input int m, input int i, input int tag, input int rob, input logic [XLEN-1:0] val);
        p_v[m][i] = 1;
        p_t[m][i] = TAGW'(tag);
        p_r[m][i] = ROBW'(rob);
        p_d[m][i] = val;
    endtask

    task automatic compare_bus();
        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < wid(m); s++) begin
                check($sformatf("w%0d.cdb_valid[%0d]", wid(m), s), obs_f(m, s, 0), 64'(e_v[m][s]));
                if (e_v[m][s] || e_rst[m]) begin
                    check($sformatf("w%0d.cdb_tag[%0d]", wid(m), s), obs_f(m, s, 1), 64'(e_t[m][s]));
                    check($sformatf("w%0d.cdb_rob[%0d]", wid(m), s), obs_f(m, s, 2), 64'(e_r[m][s]));
                    check($sformatf("w%0d.cdb_value[%0d]", wid(m), s), obs_f(m, s, 3), 64'(e_d[m][s]));
                end
            end
        end
    endtask

    // One clock: check readiness, present pending results, advance model, check the bus.
    task automatic step(input bit rst, input bit fl, input bit rnd);
        for (int m = 0; m < 2; m++) begin
            bit [3:0] hv;
            model_pick(m);
            for (int i = 0; i < 4; i++) hv[i] = m_hv[m][i];
            rdy_exp[m] = ~hv | pk_g[m];
            check($sformatf("w%0d.fu_ready", wid(m)), 64'((m == 0) ? rdy1 : rdy2), 64'(rdy_exp[m]));
        end
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 4; i++) begin
                if (rnd && !p_v[m][i] && ($urandom_range(0, 99) < 45))
                    load(m, i, int'($urandom_range(0, 127)), int'($urandom_range(0, 63)), $urandom);
                in_v[m][i] = p_v[m][i];
                in_t[m][i] = p_t[m][i];
                in_r[m][i] = p_r[m][i];
                in_d[m][i] = p_d[m][i];
            end
        end
        reset = rst;
        flush = fl;
        @(posedge clock);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                model_clear(m);
            end else if (fl) begin
                for (int i = 0; i < 4; i++) m_hv[m][i] = 0;
                for (int s = 0; s < 2; s++) e_v[m][s] = 0;
                m_rr[m]  = 0;
                e_rst[m] = 0;
            end else begin
                for (int s = 0; s < 2; s++) begin
                    e_v[m][s] = (s < pk_n[m]);
                    if (s < pk_n[m]) begin
                        e_t[m][s] = m_ht[m][pk_list[m][s]];
                        e_r[m][s] = m_hr[m][pk_list[m][s]];
                        e_d[m][s] = m_hd[m][pk_list[m][s]];
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (p_v[m][i] && rdy_exp[m][i]) begin
                        m_hv[m][i] = 1;
                        m_ht[m][i] = p_t[m][i];
                        m_hr[m][i] = p_r[m][i];
                        m_hd[m][i] = p_d[m][i];
                    end else if (pk_g[m][i]) begin
                        m_hv[m][i] = 0;
                    end
                end
                if (pk_n[m] > 0) m_rr[m] = (pk_list[m][pk_n[m] - 1] + 1) % 4;
                e_rst[m] = 0;
            end
            for (int i = 0; i < 4; i++) begin
                if (p_v[m][i] && (rst || fl || rdy_exp[m][i])) p_v[m][i] = 0;
            end
        end
        #1;
        compare_bus();
    endtask

    initial begin
        int seq;
        reset = 1'b1;
        flush = 1'b0;
        for (int m = 0; m < 2; m++) begin
            in_v[m] = '0; in_t[m] = '0; in_r[m] = '0; in_d[m] = '0;
            for (int i = 0; i < 4; i++) p_v[m][i] = 0;
            model_clear(m);
        end
        @(posedge clock);
        @(posedge clock);
        #1;
        compare_bus();
        step(1, 0, 0);

        // single ALU result, latency one
        for (int m = 0; m < 2; m++) load(m, FU_IDX_ALU, 5, 3, 32'h1234);
        repeat (3) step(0, 0, 0);

        // four-way contention from pointer 0
        step(0, 1, 0);
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 4; i++) load(m, i, 10 + i, i, 32'(100 + i));
        repeat (6) step(0, 0, 0);

        // continuous ALU stream with one MUL result mixed in
        seq = 20;
        for (int c = 0; c < 10; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!p_v[m][FU_IDX_ALU]) load(m, FU_IDX_ALU, seq + m * 40, c, 32'(seq));
                if (c == 1) load(m, FU_IDX_MUL, 40, 9, 32'hdead);
            end
            seq++;
            step(0, 0, 0);
        end
        repeat (3) step(0, 0, 0);

        // ALU, LOAD, BR together from pointer 0
        step(0, 1, 0);
        for (int m = 0; m < 2; m++) begin
            load(m, FU_IDX_ALU, 1, 1, 32'h11);
            load(m, FU_IDX_LOAD, 2, 2, 32'h22);
            load(m, FU_IDX_BR, 3, 3, 32'h33);
        end
        repeat (4) step(0, 0, 0);

        // flush with MUL/BR held and LOAD arriving
        for (int m = 0; m < 2; m++) begin
            load(m, FU_IDX_ALU, 7, 7, 32'h77);
            load(m, FU_IDX_MUL, 8, 8, 32'h88);
            load(m, FU_IDX_BR, 9, 9, 32'h99);
        end
        step(0, 0, 0);
        for (int m = 0; m < 2; m++) load(m, FU_IDX_LOAD, 12, 12, 32'hcc);
        step(0, 1, 0);
        repeat (4) step(0, 0, 0);

        // reset with everything pending, then a fresh result
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 4; i++) load(m, i, 50 + i, i, 32'(500 + i));
        step(0, 0, 0);
        step(1, 0, 0);
        for (int m = 0; m < 2; m++) load(m, FU_IDX_BR, 0, 63, 32'hffff_ffff);
        repeat (3) step(0, 0, 0);

        // random traffic with occasional flush and reset
        for (int c = 0; c < 2000; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            step(r == 0, (r >= 1) && (r <= 3), 1);
        end
        repeat (5) step(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
